// File: rtl/div_pkg.sv
// Shared types, constants and the per-step helper for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ITER,
        ST_LAST,
        ST_DONE,
        ST_SPEC
    } div_state_e;

    localparam int unsigned DIV_ITERS     = 16;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_INT_MIN   = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quo;
    } div_step_t;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits.
    function automatic div_step_t div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dvs);
        logic [32:0] trial;
        div_step_t   res;
        trial   = {rem, quo[31]};
        res.quo = {quo[30:0], 1'b0};
        if (trial >= {1'b0, dvs}) begin
            trial      = trial - {1'b0, dvs};
            res.quo[0] = 1'b1;
        end
        res.rem = trial[31:0];
        return res;
    endfunction

endpackage

// File: rtl/div_ctrl_long_div.sv
// Radix-4 (2 bits/cycle) restoring divider core on magnitudes, with sign
// fix-up applied on the final strobe. Datapath registers are not reset.
module long_div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        d_init,
    input  logic        e_advance,
    input  logic        e_last,
    input  logic        unsign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] quot,
    output logic [31:0] remd
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] dq_q, dq_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] remd_q, remd_d;

    logic        a_neg;
    logic        b_neg;
    div_step_t   s1;
    div_step_t   s2;

    assign a_neg = ~unsign & a[31];
    assign b_neg = ~unsign & b[31];

    // Load magnitudes, retire two quotient bits per advance, fix signs on last.
    always_comb begin
        rem_d  = rem_q;
        dq_d   = dq_q;
        dvs_d  = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        quot_d = quot_q;
        remd_d = remd_q;
        s1     = div_step(rem_q, dq_q, dvs_q);
        s2     = div_step(s1.rem, s1.quo, dvs_q);
        if (d_init) begin
            rem_d  = '0;
            dq_d   = a_neg ? -a : a;
            dvs_d  = b_neg ? -b : b;
            negq_d = a_neg ^ b_neg;
            negr_d = a_neg;
        end else if (e_advance) begin
            rem_d = s2.rem;
            dq_d  = s2.quo;
        end else if (e_last) begin
            quot_d = negq_q ? -dq_q : dq_q;
            remd_d = negr_q ? -rem_q : rem_q;
        end
    end

    // Datapath registers; the next d_init reinitialises them.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        dq_q   <= dq_d;
        dvs_q  <= dvs_d;
        negq_q <= negq_d;
        negr_q <= negr_d;
        quot_q <= quot_d;
        remd_q <= remd_d;
    end

    assign quot = quot_q;
    assign remd = remd_q;

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for long_div: handshakes, special cases, flush.
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned ITERS = DIV_ITERS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        kill,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    localparam logic [3:0] CNT_LAST = 4'(ITERS - 1);

    div_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    div_op_e     op_q, op_d;
    logic [31:0] spec_q, spec_d;

    logic        d_init;
    logic        e_advance;
    logic        e_last;
    logic [31:0] quot;
    logic [31:0] remd;
    logic        op_is_rem;

    assign op_is_rem = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);

    long_div u_long_div (
        .clk       (clk),
        .d_init    (d_init),
        .e_advance (e_advance),
        .e_last    (e_last),
        .unsign    (in_op[0]),
        .a         (in_a),
        .b         (in_b),
        .quot      (quot),
        .remd      (remd)
    );

    // Next-state, core strobes and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        spec_d     = spec_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_result = '0;
        d_init     = 1'b0;
        e_advance  = 1'b0;
        e_last     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~kill;
                if (in_valid && !kill) begin
                    op_d = div_op_e'(in_op);
                    if (in_b == '0) begin
                        state_d = ST_SPEC;
                        spec_d  = in_op[1] ? in_a : DIV_ZERO_QUOT;
                    end else if (!in_op[0] && in_a == DIV_INT_MIN && in_b == '1) begin
                        state_d = ST_SPEC;
                        spec_d  = in_op[1] ? '0 : DIV_INT_MIN;
                    end else begin
                        d_init  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                e_advance = 1'b1;
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                e_last  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid  = 1'b1;
                out_result = op_is_rem ? remd : quot;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SPEC: begin
                out_valid  = 1'b1;
                out_result = spec_q;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d   = ST_IDLE;
            d_init    = 1'b0;
            e_advance = 1'b0;
            e_last    = 1'b0;
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= DIV_OP_DIV;
            spec_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            spec_q  <= spec_d;
        end
    end

    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized checks of div_ctrl against a behavioural model.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        busy;
    logic [2:0]  strb;

    int unsigned checks = 0;
    int unsigned errors = 0;

    div_ctrl #(.ITERS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .kill       (kill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    assign strb = {dut.d_init, dut.e_advance, dut.e_last};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V divide semantics computed with wide integer arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (op[0]) begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end else begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        if (y == 0) begin
            q = -1;
            r = x;
        end else begin
            q = x / y;
            r = x % y;
        end
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    // Issue one operation, check every cycle's strobes, then hand off after
    // 'stall' cycles of out_ready low.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int unsigned stall);
        bit          spec;
        int unsigned lat;
        spec = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat  = spec ? 1 : 18;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = (stall == 0);
        #1;
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        chk("accept_strobes", 32'(strb), spec ? 32'd0 : 32'd4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int unsigned k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("iter_strobes", 32'(strb), (k <= 16) ? 32'd2 : 32'd1);
            chk("iter_out_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk("res_valid", 32'(out_valid), 32'd1);
        chk("res_value", out_result, exp);
        chk("res_strobes", 32'(strb), 32'd0);
        chk("res_in_ready", 32'(in_ready), 32'd0);
        chk("res_busy", 32'(busy), 32'd1);
        for (int unsigned s = 1; s <= stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_value", out_result, exp);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            out_ready = (s == stall);
        end
        @(negedge clk);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_result"}, out_result, 32'd0);
        chk({tag, "_strobes"}, 32'(strb), 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        #3;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic, including special cases
        do_op(2'b00, 32'd100, 32'd7, 32'd14, 0);
        do_op(2'b10, 32'd100, 32'd7, 32'd2, 0);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        do_op(2'b01, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 0);
        do_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'd5, 32'd0, 32'd5, 0);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

        // Backpressure: five cycles held, handoff on the sixth
        do_op(2'b00, 32'd100, 32'd7, 32'd14, 5);
        do_op(2'b10, 32'd5, 32'd0, 32'd5, 3);

        // Flush mid-iteration
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd100; in_b = 32'd7; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        @(negedge clk);
        kill = 1'b1;
        #1;
        chk("kill_strobes", 32'(strb), 32'd0);
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_out_valid", 32'(out_valid), 32'd0);
        chk("kill_in_ready", 32'(in_ready), 32'd1);
        chk("kill_busy", 32'(busy), 32'd0);
        for (int unsigned k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("kill_quiet_valid", 32'(out_valid), 32'd0);
        end
        do_op(2'b00, 32'd9, 32'd3, 32'd3, 0);

        // Kill coincident with a request in IDLE
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd9; in_b = 32'd3; kill = 1'b1;
        #1;
        chk("kill_idle_in_ready", 32'(in_ready), 32'd0);
        chk("kill_idle_strobes", 32'(strb), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; kill = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("kill_idle_busy", 32'(busy), 32'd0);
            chk("kill_idle_valid", 32'(out_valid), 32'd0);
        end

        // Kill while a result is presented and not taken
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_a = 32'd7; in_b = 32'd0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("kill_spec_valid", 32'(out_valid), 32'd1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_spec_gone", 32'(out_valid), 32'd0);
        chk("kill_spec_in_ready", 32'(in_ready), 32'd1);

        // Reset asserted mid-operation
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd100; in_b = 32'd7; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2'b00, 32'd9, 32'd3, 32'd3, 0);

        // Randomized operations against the reference model
        for (int unsigned n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 1000));
                default: ra = $urandom;
            endcase
            do_op(rop, ra, rb, ref_div(rop, ra, rb), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
